// File: rtl/mem_port_arbiter.sv
// Shares the single data-cache port between issue lanes A (older) and B
// (younger) of the Memory stage. Accesses are serialized A-then-B over the
// Den/DReady handshake while StallM freezes the front of the pipeline.
// Misaligned word accesses are flagged and skipped. A saturating counter
// tracks the number of stalled cycles.
module mem_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemReqA,
  input  logic             MemReqB,
  input  logic             MemWriteA,
  input  logic             MemWriteB,
  input  logic [WIDTH-1:0] AddrA,
  input  logic [WIDTH-1:0] AddrB,
  input  logic [WIDTH-1:0] WDataA,
  input  logic [WIDTH-1:0] WDataB,
  output logic             Den,
  output logic             DWen,
  output logic [WIDTH-1:0] DAddr,
  output logic [WIDTH-1:0] DWriteData,
  input  logic [WIDTH-1:0] DReadData,
  input  logic             DReady,
  output logic [WIDTH-1:0] ReadDataA,
  output logic [WIDTH-1:0] ReadDataB,
  output logic             AddrErrA,
  output logic             AddrErrB,
  output logic             StallM,
  output logic [CNT_W-1:0] StallCnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERV_A = 2'd1,
    SERV_B = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic mis_a;
  logic mis_b;
  logic any_req;
  logic go_a;
  logic go_b;
  logic leave_idle;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // A lane is only sent to the cache when it requests and is word aligned.
  assign mis_a      = (AddrA[1:0] != 2'b00);
  assign mis_b      = (AddrB[1:0] != 2'b00);
  assign any_req    = MemReqA | MemReqB;
  assign go_a       = MemReqA & ~mis_a;
  assign go_b       = MemReqB & ~mis_b;
  assign leave_idle = (state == IDLE) && any_req;

  // State register; reset abandons any in-flight cache request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: A before B, misaligned lanes skipped entirely.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (go_a) begin
          state_next = SERV_A;
        end else if (go_b) begin
          state_next = SERV_B;
        end else if (any_req) begin
          state_next = FINISH;
        end
      end
      SERV_A: begin
        if (DReady) begin
          state_next = go_b ? SERV_B : FINISH;
        end
      end
      SERV_B: begin
        if (DReady) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Cache-port drive and pipeline stall; bus is zero outside SERV states.
  always_comb begin
    Den        = 1'b0;
    DWen       = 1'b0;
    DAddr      = '0;
    DWriteData = '0;
    StallM     = 1'b0;
    unique case (state)
      IDLE: begin
        StallM = any_req & ~reset;
      end
      SERV_A: begin
        Den        = 1'b1;
        DWen       = MemWriteA;
        DAddr      = AddrA;
        DWriteData = WDataA;
        StallM     = 1'b1;
      end
      SERV_B: begin
        Den        = 1'b1;
        DWen       = MemWriteB;
        DAddr      = AddrB;
        DWriteData = WDataB;
        StallM     = 1'b1;
      end
      FINISH: begin
        StallM = 1'b0;
      end
      default: begin
        StallM = 1'b0;
      end
    endcase
  end

  // Load capture per lane; stores leave the last loaded value untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ReadDataA <= '0;
      ReadDataB <= '0;
    end else begin
      if ((state == SERV_A) && DReady && !MemWriteA) begin
        ReadDataA <= DReadData;
      end
      if ((state == SERV_B) && DReady && !MemWriteB) begin
        ReadDataB <= DReadData;
      end
    end
  end

  // Misalignment flags for the pair, latched as the pair is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      AddrErrA <= 1'b0;
      AddrErrB <= 1'b0;
    end else if (leave_idle) begin
      AddrErrA <= MemReqA & mis_a;
      AddrErrB <= MemReqB & mis_b;
    end
  end

  // Performance counter of stalled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCnt <= '0;
    end else if (StallM) begin
      StallCnt <= sat_inc(StallCnt);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Stimulus pushes expected cache
// requests and expected pair results into queues; a negedge monitor pops
// and compares whenever the DUT presents a request or completes a pair.
// A second instance with a 4-bit counter shares the inputs to exercise
// counter saturation.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int W = 32;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cycles;
  } req_t;

  typedef struct {
    logic [31:0] rda;
    logic [31:0] rdb;
    logic        erra;
    logic        errb;
    int          cycles;
  } res_t;

  logic          clk;
  logic          reset;
  logic          MemReqA, MemReqB, MemWriteA, MemWriteB;
  logic [W-1:0]  AddrA, AddrB, WDataA, WDataB;
  logic          Den, DWen;
  logic [W-1:0]  DAddr, DWriteData, DReadData;
  logic          DReady;
  logic [W-1:0]  ReadDataA, ReadDataB;
  logic          AddrErrA, AddrErrB, StallM;
  logic [31:0]   StallCnt;

  logic          s_den, s_dwen, s_erra, s_errb, s_stall;
  logic [W-1:0]  s_daddr, s_dwdata, s_rda, s_rdb;
  logic [3:0]    s_cnt;

  int checks = 0;
  int errors = 0;

  req_t req_q[$];
  res_t res_q[$];

  logic [31:0] mem [logic [31:0]];
  int cfg_wait = 0;
  int remain = 0;
  bit busy = 0;

  int den_cyc = 0;
  int stall_run = 0;
  int exp_total = 0;

  mem_port_arbiter #(.WIDTH(W), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .MemReqA(MemReqA), .MemReqB(MemReqB),
    .MemWriteA(MemWriteA), .MemWriteB(MemWriteB),
    .AddrA(AddrA), .AddrB(AddrB), .WDataA(WDataA), .WDataB(WDataB),
    .Den(Den), .DWen(DWen), .DAddr(DAddr), .DWriteData(DWriteData),
    .DReadData(DReadData), .DReady(DReady),
    .ReadDataA(ReadDataA), .ReadDataB(ReadDataB),
    .AddrErrA(AddrErrA), .AddrErrB(AddrErrB),
    .StallM(StallM), .StallCnt(StallCnt)
  );

  mem_port_arbiter #(.WIDTH(W), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset),
    .MemReqA(MemReqA), .MemReqB(MemReqB),
    .MemWriteA(MemWriteA), .MemWriteB(MemWriteB),
    .AddrA(AddrA), .AddrB(AddrB), .WDataA(WDataA), .WDataB(WDataB),
    .Den(s_den), .DWen(s_dwen), .DAddr(s_daddr), .DWriteData(s_dwdata),
    .DReadData(DReadData), .DReady(DReady),
    .ReadDataA(s_rda), .ReadDataB(s_rdb),
    .AddrErrA(s_erra), .AddrErrB(s_errb),
    .StallM(s_stall), .StallCnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Cache model: real memory, answers after cfg_wait wait cycles.
  always @(posedge clk) begin
    #2;
    if (reset) begin
      busy = 0;
      DReady = 1'b0;
    end else if (Den) begin
      if (!busy) begin
        busy = 1;
        remain = cfg_wait;
      end
      if (remain == 0) begin
        DReady = 1'b1;
        busy = 0;
        if (DWen) mem[DAddr] = DWriteData;
        else DReadData = mem.exists(DAddr) ? mem[DAddr] : 32'h0;
      end else begin
        DReady = 1'b0;
        remain--;
      end
    end else begin
      DReady = 1'b0;
      busy = 0;
    end
  end

  // Monitor: checks cache requests and completed pairs.
  always @(negedge clk) begin
    if (reset) begin
      den_cyc = 0;
      stall_run = 0;
      exp_total = 0;
    end else begin
      if (Den) begin
        if (req_q.size() == 0) begin
          chk("den_unexpected", 64'(Den), 64'(0));
        end else begin
          chk("dwen", 64'(DWen), 64'(req_q[0].we));
          chk("daddr", 64'(DAddr), 64'(req_q[0].addr));
          chk("dwdata", 64'(DWriteData), 64'(req_q[0].wdata));
          den_cyc++;
          if (DReady) begin
            chk("den_cycles", 64'(den_cyc), 64'(req_q[0].cycles));
            den_cyc = 0;
            void'(req_q.pop_front());
          end
        end
      end else begin
        chk("bus_idle", {31'h0, DWen, DAddr}, 64'(0));
        chk("bus_idle_wd", 64'(DWriteData), 64'(0));
      end
      if (StallM) begin
        stall_run++;
      end else if (stall_run > 0) begin
        if (res_q.size() == 0) begin
          chk("done_unexpected", 64'(res_q.size()), 64'(1));
        end else begin
          res_t e;
          e = res_q.pop_front();
          exp_total += e.cycles;
          chk("read_a", 64'(ReadDataA), 64'(e.rda));
          chk("read_b", 64'(ReadDataB), 64'(e.rdb));
          chk("err_a", 64'(AddrErrA), 64'(e.erra));
          chk("err_b", 64'(AddrErrB), 64'(e.errb));
          chk("stall_cycles", 64'(stall_run), 64'(e.cycles));
          chk("stall_cnt", 64'(StallCnt), 64'(exp_total));
          chk("stall_cnt_sat", 64'(s_cnt), 64'((exp_total > 15) ? 15 : exp_total));
        end
        stall_run = 0;
      end
    end
  end

  task automatic exp_req(input logic we, input logic [31:0] addr, input logic [31:0] wd, input int cyc);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wd; r.cycles = cyc;
    req_q.push_back(r);
  endtask

  task automatic exp_res(input logic [31:0] rda, input logic [31:0] rdb,
                         input logic ea, input logic eb, input int cyc);
    res_t r;
    r.rda = rda; r.rdb = rdb; r.erra = ea; r.errb = eb; r.cycles = cyc;
    res_q.push_back(r);
  endtask

  task automatic clear_lanes();
    MemReqA = 0; MemReqB = 0; MemWriteA = 0; MemWriteB = 0;
    AddrA = '0; AddrB = '0; WDataA = '0; WDataB = '0;
  endtask

  // Present a pair, hold it while stalled, release it in the FINISH cycle.
  task automatic issue(input logic ra, input logic wa, input logic [31:0] aa, input logic [31:0] da,
                       input logic rb, input logic wb, input logic [31:0] ab, input logic [31:0] db,
                       input int waits);
    bit done;
    cfg_wait = waits;
    @(posedge clk); #1;
    MemReqA = ra; MemWriteA = wa; AddrA = aa; WDataA = da;
    MemReqB = rb; MemWriteB = wb; AddrB = ab; WDataB = db;
    done = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!StallM) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("timeout", 64'(StallM), 64'(0));
    clear_lanes();
    @(posedge clk);
    @(posedge clk);
  endtask

  initial begin
    clear_lanes();
    DReady = 1'b0;
    DReadData = '0;
    reset = 1'b1;
    MemReqA = 1'b1;
    #12;
    chk("stall_in_reset", 64'(StallM), 64'(0));
    clear_lanes();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_den", 64'(Den), 64'(0));
    chk("rst_rda", 64'(ReadDataA), 64'(0));
    chk("rst_rdb", 64'(ReadDataB), 64'(0));
    chk("rst_cnt", 64'(StallCnt), 64'(0));
    chk("rst_err", {62'h0, AddrErrA, AddrErrB}, 64'(0));

    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h300] = 32'hA5A55A5A;

    // Lane A load only, immediate cache.
    exp_req(0, 32'h100, 32'h0, 1);
    exp_res(32'hDEADBEEF, 32'h0, 0, 0, 2);
    issue(1, 0, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0, 0);

    // A store then B load to the same address.
    exp_req(1, 32'h200, 32'h12345678, 1);
    exp_req(0, 32'h200, 32'h0BAD0BAD, 1);
    exp_res(32'hDEADBEEF, 32'h12345678, 0, 0, 3);
    issue(1, 1, 32'h200, 32'h12345678, 1, 0, 32'h200, 32'h0BAD0BAD, 0);

    // Lane B only, cache withholds DReady for 3 cycles.
    exp_req(0, 32'h300, 32'h0, 4);
    exp_res(32'hDEADBEEF, 32'hA5A55A5A, 0, 0, 5);
    issue(0, 0, 32'h0, 32'h0, 1, 0, 32'h300, 32'h0, 3);

    // A misaligned load, B aligned store.
    exp_req(1, 32'h104, 32'hCAFEF00D, 1);
    exp_res(32'hDEADBEEF, 32'hA5A55A5A, 1, 0, 2);
    issue(1, 0, 32'h102, 32'h0, 1, 1, 32'h104, 32'hCAFEF00D, 0);

    // Both lanes misaligned: no cache traffic at all.
    exp_res(32'hDEADBEEF, 32'hA5A55A5A, 1, 1, 1);
    issue(1, 1, 32'h101, 32'h55, 1, 0, 32'h203, 32'h0, 0);
    chk("mem_104", 64'(mem[32'h104]), 64'(32'hCAFEF00D));

    // Reset while SERV_A is waiting on the cache.
    exp_req(0, 32'h400, 32'h0, 99);
    cfg_wait = 5;
    @(posedge clk); #1;
    MemReqA = 1; AddrA = 32'h400;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("serv_den", 64'(Den), 64'(1));
    chk("serv_dready", 64'(DReady), 64'(0));
    reset = 1'b1;
    #1;
    chk("arst_den", {62'h0, Den, DWen}, 64'(0));
    chk("arst_daddr", 64'(DAddr), 64'(0));
    chk("arst_dwdata", 64'(DWriteData), 64'(0));
    chk("arst_stall", 64'(StallM), 64'(0));
    chk("arst_rda", 64'(ReadDataA), 64'(0));
    chk("arst_rdb", 64'(ReadDataB), 64'(0));
    chk("arst_cnt", 64'(StallCnt), 64'(0));
    clear_lanes();
    req_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_den", 64'(Den), 64'(0));
    chk("post_rst_stall", 64'(StallM), 64'(0));
    chk("post_rst_rda", 64'(ReadDataA), 64'(0));

    // 20 stalled cycles: the 4-bit counter must stop at 15.
    exp_req(0, 32'h300, 32'h0, 19);
    exp_res(32'h0, 32'hA5A55A5A, 0, 0, 20);
    issue(0, 0, 32'h0, 32'h0, 1, 0, 32'h300, 32'h0, 18);
    chk("sat_final", 64'(s_cnt), 64'(15));
    chk("cnt_final", 64'(StallCnt), 64'(20));

    chk("req_q_drained", 64'(req_q.size()), 64'(0));
    chk("res_q_drained", 64'(res_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares the single data-cache port between the two issue lanes (A = older, B = younger) of the dual-issue pipeline's Memory stage. Each cycle either lane may present a load or store. The block serializes the accesses in program order (A before B) over the DCache handshake and holds the whole pipeline with `StallM` until every access of the current pair has completed. It also flags misaligned word addresses and keeps a saturating stall-cycle performance counter.

## Interface
- `WIDTH`, 32, address/data width
- `CNT_W`, 32, width of the stall performance counter
- `clk`  in  1  pipeline clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `MemReqA` / `MemReqB`  in  1  lane has a memory op in M stage (MemWrite | MemtoReg)
- `MemWriteA` / `MemWriteB`  in  1  op is a store (else load)
- `AddrA` / `AddrB`  in  WIDTH  byte address from ALUOut
- `WDataA` / `WDataB`  in  WIDTH  store data
- `Den`  out  1  cache request valid
- `DWen`  out  1  cache write enable (store)
- `DAddr`  out  WIDTH  cache address
- `DWriteData`  out  WIDTH  cache store data
- `DReadData`  in  WIDTH  cache load data, valid with `DReady`
- `DReady`  in  1  cache completes current request this cycle
- `ReadDataA` / `ReadDataB`  out  WIDTH  registered load results
- `AddrErrA` / `AddrErrB`  out  1  misaligned-access flag for the completed pair
- `StallM`  out  1  freeze F/D/E/M stage registers
- `StallCnt`  out  CNT_W  saturating count of cycles with `StallM`=1

## Operation
- FSM states: IDLE, SERV_A, SERV_B, FINISH.
- Misaligned access: `Addr[1:0]` != 0. A misaligned op is never sent to the cache. Its error flag is latched, and it is treated as completed.
- IDLE
  - `Den`=0.
  - `StallM` = `MemReqA` | `MemReqB` (combinational).
  - Next state:
    - SERV_A if `MemReqA` is set and A is aligned.
    - Else SERV_B if `MemReqB` is set and B is aligned.
    - Else FINISH if any request is present (all requests misaligned).
    - Else stay in IDLE.
  - On leaving IDLE, latch `AddrErrA`/`AddrErrB` and clear them for lanes without a request.
- SERV_A
  - `Den`=1, `DAddr`=`AddrA`, `DWen`=`MemWriteA`, `DWriteData`=`WDataA`, `StallM`=1.
  - On `DReady`: if the op is a load, `ReadDataA` <= `DReadData`.
  - Next state after `DReady`: SERV_B if `MemReqB` is set and B is aligned, else FINISH.
  - Without `DReady`: stay in SERV_A and hold all outputs stable.
- SERV_B
  - Same as SERV_A but for lane B; loads capture into `ReadDataB`.
  - On `DReady`: go to FINISH.
- FINISH
  - `Den`=0, `StallM`=0, so the pipeline advances this cycle.
  - `ReadDataA/B` and `AddrErr*` are valid for the W-stage register.
  - Next state: always IDLE.
- Outside SERV_*: `DAddr`, `DWriteData` and `DWen` are driven to 0.
- Lane inputs are only sampled while `StallM`=1. Upstream guarantees they are stable while stalled.
- Ordering: A always completes before B, so an A store followed by a B load to the same address returns the new data.
- `ReadDataA/B` hold their value until the next load capture on that lane. Stores do not modify them.
- `StallCnt` increments on every cycle with `StallM`=1 and saturates at all-ones.

## Timing
- Reset (asynchronous):
  - State = IDLE.
  - `ReadDataA/B`, `AddrErrA/B` and `StallCnt` = 0.
  - `Den`, `DWen`, `DAddr` and `DWriteData` = 0.
  - `StallM` = 0 while `reset` is high.
- Reset mid-access: any in-flight cache request is abandoned immediately and no capture occurs.
- Latency with a cache that answers `DReady` in the same cycle:
  - Single op: 3 cycles, of which 2 are stalled (IDLE, SERV, FINISH).
  - Dual op: 4 cycles, of which 3 are stalled.
- Each cache wait cycle adds 1 stalled cycle.
- No request: the block stays in IDLE with `StallM`=0 and adds zero cycles.
- `Den` and address/data are asserted for exactly the cycles in SERV_* and are held until `DReady`.
- Exactly one `DReady` is consumed per request.
- `DReady` while in IDLE or FINISH is ignored.

## Test plan
- Lane A load only:
  - Stimulus: `AddrA`=0x100, cache returns 0xDEADBEEF with `DReady` on the first SERV cycle.
  - Required: `Den`=1 for 1 cycle with `DAddr`=0x100, `DWen`=0; `ReadDataA`=0xDEADBEEF at FINISH; `StallM` high for 2 cycles.
- Dual op, A store then B load to the same address:
  - Stimulus: A stores 0x12345678 to 0x200; B loads 0x200; the cache model is a real memory.
  - Required: A is issued first, then B; `ReadDataB`=0x12345678; `StallM` high for 3 cycles.
- Lane B only with a slow cache:
  - Stimulus: B loads 0x300; `DReady` is withheld for 3 cycles.
  - Required: `DAddr`=0x300 is held stable for 4 SERV_B cycles; `StallM` is high for 5 cycles; `StallCnt` rises by 5.
- Misaligned access:
  - Stimulus: `AddrA`=0x102 load together with a B store to 0x104.
  - Required: `AddrErrA`=1 and `AddrErrB`=0; only the B store is issued (`DWen`=1 with `DAddr`=0x104).
  - Stimulus: both lanes misaligned.
  - Required: `Den` is never asserted; IDLE goes straight to FINISH.
- Reset in SERV_A:
  - Stimulus: assert `reset` while `Den`=1 and `DReady`=0.
  - Required: all outputs go to 0 asynchronously; after release the block is in IDLE and `ReadDataA`=0.
- Counter saturation:
  - Stimulus: `CNT_W`=4; run 20 stalled cycles.
  - Required: `StallCnt` holds at 15.
